clock_set_controller: RTL and testbench

- Mode/edit controller for the digitalClock datapath.
- Turns three debounced single-cycle button pulses into time-load and alarm-configuration commands.
- Owns the alarm registers, the alarm-enable bit and a latched ringing indicator.
- Sits between the front-panel debouncers and digitalClock: drives the clock's load port and its alarm_hour/alarm_min/alarm_sec inputs.

---
 rtl/clock_set_if.sv | 34 +++
 rtl/clock_set_controller.sv | 222 ++++++++++++++++++++++
 tb/tb_clock_set_controller.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/clock_set_if.sv
// Bundle of button, running-time, load and alarm signals between the front panel,
// the set controller (master) and the digitalClock datapath (slave).
interface clock_set_if;
    logic       btn_mode;
    logic       btn_inc;
    logic       btn_dec;
    logic [4:0] cur_hour;
    logic [5:0] cur_min;
    logic [5:0] cur_sec;
    logic       load;
    logic [4:0] load_hour;
    logic [5:0] load_min;
    logic [5:0] load_sec;
    logic [4:0] alarm_hour;
    logic [5:0] alarm_min;
    logic [5:0] alarm_sec;
    logic       alarm_en;
    logic       ringing;
    logic [2:0] mode;
    logic [4:0] disp_hour;
    logic [5:0] disp_min;

    modport master (
        input  btn_mode, btn_inc, btn_dec, cur_hour, cur_min, cur_sec,
        output load, load_hour, load_min, load_sec, alarm_hour, alarm_min, alarm_sec,
        output alarm_en, ringing, mode, disp_hour, disp_min
    );

    modport slave (
        output btn_mode, btn_inc, btn_dec, cur_hour, cur_min, cur_sec,
        input  load, load_hour, load_min, load_sec, alarm_hour, alarm_min, alarm_sec,
        input  alarm_en, ringing, mode, disp_hour, disp_min
    );
endinterface

// File: rtl/clock_set_controller.sv
// Mode/edit FSM for digitalClock: time load, alarm programming, arm bit and ringing latch.
// Optional snooze (re-ring SNOOZE_MIN later per btn_inc) is built when CLOCK_SNOOZE_EN is defined.
module clock_set_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 30
`ifdef CLOCK_SNOOZE_EN
    , parameter int unsigned SNOOZE_MIN = 5
`endif
) (
    input logic        clk,
    input logic        reset,
    clock_set_if.master bus
);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        StRun     = 3'd0,
        StSetHour = 3'd1,
        StSetMin  = 3'd2,
        StAlmHour = 3'd3,
        StAlmMin  = 3'd4,
        StAlmArm  = 3'd5
    } state_e;

    state_e        mode_q, mode_d;
    logic          load_q, load_d;
    logic [4:0]    load_hour_q, load_hour_d;
    logic [5:0]    load_min_q, load_min_d;
    logic [4:0]    alarm_hour_q, alarm_hour_d;
    logic [5:0]    alarm_min_q, alarm_min_d;
    logic          alarm_en_q, alarm_en_d;
    logic          ringing_q, ringing_d;
    logic [4:0]    edit_hour_q, edit_hour_d;
    logic [5:0]    edit_min_q, edit_min_d;
    logic [TW-1:0] tmo_q, tmo_d;

    logic       any_btn, inc_only, dec_only, match_alarm;
    logic [4:0] hour_up, hour_dn;
    logic [5:0] min_up, min_dn;

`ifdef CLOCK_SNOOZE_EN
    logic       snz_act_q, snz_act_d;
    logic [4:0] snz_hour_q, snz_hour_d;
    logic [5:0] snz_min_q, snz_min_d;
    logic       match_snz;
    logic [4:0] base_hour;
    logic [5:0] base_min;
    logic [6:0] min_sum;
`endif

    always_comb begin
        any_btn  = bus.btn_mode | bus.btn_inc | bus.btn_dec;
        inc_only = bus.btn_inc & ~bus.btn_dec;
        dec_only = bus.btn_dec & ~bus.btn_inc;
        hour_up  = (edit_hour_q == 5'd23) ? 5'd0 : edit_hour_q + 5'd1;
        hour_dn  = (edit_hour_q == 5'd0) ? 5'd23 : edit_hour_q - 5'd1;
        min_up   = (edit_min_q == 6'd59) ? 6'd0 : edit_min_q + 6'd1;
        min_dn   = (edit_min_q == 6'd0) ? 6'd59 : edit_min_q - 6'd1;
        match_alarm = (mode_q == StRun) && alarm_en_q && (bus.cur_hour == alarm_hour_q) &&
                      (bus.cur_min == alarm_min_q) && (bus.cur_sec == 6'd0);

        mode_d       = mode_q;
        load_d       = 1'b0;
        load_hour_d  = load_hour_q;
        load_min_d   = load_min_q;
        alarm_hour_d = alarm_hour_q;
        alarm_min_d  = alarm_min_q;
        alarm_en_d   = alarm_en_q;
        ringing_d    = ringing_q;
        edit_hour_d  = edit_hour_q;
        edit_min_d   = edit_min_q;
        tmo_d        = (mode_q == StRun) ? '0 : tmo_q + TW'(1);

`ifdef CLOCK_SNOOZE_EN
        snz_act_d  = snz_act_q;
        snz_hour_d = snz_hour_q;
        snz_min_d  = snz_min_q;
        match_snz  = (mode_q == StRun) && alarm_en_q && snz_act_q &&
                     (bus.cur_hour == snz_hour_q) && (bus.cur_min == snz_min_q) &&
                     (bus.cur_sec == 6'd0);
        // Successive snoozes step on from the previous target, i.e. alarm + n*SNOOZE_MIN.
        base_hour = snz_act_q ? snz_hour_q : alarm_hour_q;
        base_min  = snz_act_q ? snz_min_q : alarm_min_q;
        min_sum   = {1'b0, base_min} + 7'(SNOOZE_MIN);
`endif

        if (ringing_q && any_btn) begin
            // The silencing press is consumed here and does nothing else.
            ringing_d = 1'b0;
`ifdef CLOCK_SNOOZE_EN
            if (bus.btn_inc && !bus.btn_dec && !bus.btn_mode) begin
                snz_act_d = 1'b1;
                if (min_sum >= 7'd60) begin
                    snz_min_d  = 6'(min_sum - 7'd60);
                    snz_hour_d = (base_hour == 5'd23) ? 5'd0 : base_hour + 5'd1;
                end else begin
                    snz_min_d  = min_sum[5:0];
                    snz_hour_d = base_hour;
                end
            end else begin
                snz_act_d = 1'b0;
            end
`endif
        end else begin
            if (bus.btn_mode) begin
                unique case (mode_q)
                    StRun: begin
                        mode_d      = StSetHour;
                        edit_hour_d = bus.cur_hour;
                        edit_min_d  = bus.cur_min;
                    end
                    StSetHour: mode_d = StSetMin;
                    StSetMin: begin
                        mode_d      = StAlmHour;
                        load_d      = 1'b1;
                        load_hour_d = edit_hour_q;
                        load_min_d  = edit_min_q;
                        edit_hour_d = alarm_hour_q;
                        edit_min_d  = alarm_min_q;
                    end
                    StAlmHour: mode_d = StAlmMin;
                    StAlmMin: begin
                        mode_d       = StAlmArm;
                        alarm_hour_d = edit_hour_q;
                        alarm_min_d  = edit_min_q;
`ifdef CLOCK_SNOOZE_EN
                        snz_act_d = 1'b0;
`endif
                    end
                    default: mode_d = StRun;
                endcase
                tmo_d = '0;
            end else if (bus.btn_inc || bus.btn_dec) begin
                unique case (mode_q)
                    StSetHour, StAlmHour: begin
                        if (inc_only) edit_hour_d = hour_up;
                        if (dec_only) edit_hour_d = hour_dn;
                    end
                    StSetMin, StAlmMin: begin
                        if (inc_only) edit_min_d = min_up;
                        if (dec_only) edit_min_d = min_dn;
                    end
                    StAlmArm: begin
                        if (inc_only || dec_only) alarm_en_d = ~alarm_en_q;
                    end
                    default: ;
                endcase
                tmo_d = '0;
            end else if (mode_q != StRun && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                mode_d = StRun;
            end

            if (match_alarm && mode_d == StRun) begin
                ringing_d = 1'b1;
`ifdef CLOCK_SNOOZE_EN
                snz_act_d = 1'b0;
            end else if (match_snz && mode_d == StRun) begin
                ringing_d = 1'b1;
`endif
            end
        end

        if (mode_q > StAlmArm) mode_d = StRun;
        if (mode_d != mode_q) tmo_d = '0;
        if (!alarm_en_d) begin
            ringing_d = 1'b0;
`ifdef CLOCK_SNOOZE_EN
            snz_act_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q       <= StRun;
            load_q       <= 1'b0;
            load_hour_q  <= '0;
            load_min_q   <= '0;
            alarm_hour_q <= '0;
            alarm_min_q  <= '0;
            alarm_en_q   <= 1'b0;
            ringing_q    <= 1'b0;
            edit_hour_q  <= '0;
            edit_min_q   <= '0;
            tmo_q        <= '0;
`ifdef CLOCK_SNOOZE_EN
            snz_act_q    <= 1'b0;
            snz_hour_q   <= '0;
            snz_min_q    <= '0;
`endif
        end else begin
            mode_q       <= mode_d;
            load_q       <= load_d;
            load_hour_q  <= load_hour_d;
            load_min_q   <= load_min_d;
            alarm_hour_q <= alarm_hour_d;
            alarm_min_q  <= alarm_min_d;
            alarm_en_q   <= alarm_en_d;
            ringing_q    <= ringing_d;
            edit_hour_q  <= edit_hour_d;
            edit_min_q   <= edit_min_d;
            tmo_q        <= tmo_d;
`ifdef CLOCK_SNOOZE_EN
            snz_act_q    <= snz_act_d;
            snz_hour_q   <= snz_hour_d;
            snz_min_q    <= snz_min_d;
`endif
        end
    end

    assign bus.load       = load_q;
    assign bus.load_hour  = load_hour_q;
    assign bus.load_min   = load_min_q;
    assign bus.load_sec   = '0;
    assign bus.alarm_hour = alarm_hour_q;
    assign bus.alarm_min  = alarm_min_q;
    assign bus.alarm_sec  = '0;
    assign bus.alarm_en   = alarm_en_q;
    assign bus.ringing    = ringing_q;
    assign bus.mode       = mode_q;
    assign bus.disp_hour  = (mode_q == StRun) ? bus.cur_hour : edit_hour_q;
    assign bus.disp_min   = (mode_q == StRun) ? bus.cur_min : edit_min_q;
endmodule

// File: tb/tb_clock_set_controller.sv
// Directed bench for clock_set_controller: edits, load pulse, alarm ring, timeout, priority,
// snooze re-ring (expectation follows CLOCK_SNOOZE_EN) and mid-operation reset.
module tb_clock_set_controller;
    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;
    int   load_cnt = 0;
    int   load_base;

`ifdef CLOCK_SNOOZE_EN
    localparam logic [31:0] SnzRing = 32'd1;
`else
    localparam logic [31:0] SnzRing = 32'd0;
`endif

    clock_set_if bus ();

    clock_set_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Counts cycles in which load was high before the edge.
    always @(posedge clk) if (bus.load) load_cnt <= load_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic m, input logic i, input logic d);
        bus.btn_mode = m;
        bus.btn_inc  = i;
        bus.btn_dec  = d;
        @(negedge clk);
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        bus.btn_dec  = 1'b0;
    endtask

    task automatic set_cur(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        bus.cur_hour = h;
        bus.cur_min  = m;
        bus.cur_sec  = s;
    endtask

    initial begin
        reset = 1'b1;
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        bus.btn_dec  = 1'b0;
        set_cur(5'd0, 6'd0, 6'd0);
        repeat (2) @(negedge clk);
        check("rst_mode", 32'(bus.mode), 0);
        check("rst_load", 32'(bus.load), 0);
        check("rst_load_hour", 32'(bus.load_hour), 0);
        check("rst_alarm_min", 32'(bus.alarm_min), 0);
        check("rst_alarm_en", 32'(bus.alarm_en), 0);
        check("rst_ringing", 32'(bus.ringing), 0);
        reset = 1'b0;

        // Time set 00:00 -> 03:58 and load.
        pulse(1, 0, 0);
        check("enter_set_hour", 32'(bus.mode), 1);
        repeat (3) pulse(0, 1, 0);
        check("edit_hour_3", 32'(bus.disp_hour), 3);
        pulse(1, 0, 0);
        check("enter_set_min", 32'(bus.mode), 2);
        repeat (2) pulse(0, 0, 1);
        check("edit_min_58", 32'(bus.disp_min), 58);
        load_base = load_cnt;
        pulse(1, 0, 0);
        check("load_pulse", 32'(bus.load), 1);
        check("load_hour", 32'(bus.load_hour), 3);
        check("load_min", 32'(bus.load_min), 58);
        check("load_sec", 32'(bus.load_sec), 0);
        check("mode_alm_hour", 32'(bus.mode), 3);
        check("alm_edit_from_alarm", 32'(bus.disp_hour), 0);
        @(negedge clk);
        check("load_dropped", 32'(bus.load), 0);
        check("load_count_1", 32'(load_cnt - load_base), 1);

        // Alarm 00:01, arm, back to RUN.
        pulse(1, 0, 0);
        pulse(0, 1, 0);
        check("alm_edit_min", 32'(bus.disp_min), 1);
        pulse(1, 0, 0);
        check("mode_alm_arm", 32'(bus.mode), 5);
        check("alarm_committed", 32'(bus.alarm_min), 1);
        pulse(0, 1, 1);
        check("arm_inc_dec_cancel", 32'(bus.alarm_en), 0);
        pulse(0, 1, 0);
        check("arm_toggle", 32'(bus.alarm_en), 1);
        pulse(1, 0, 0);
        check("back_to_run", 32'(bus.mode), 0);

        // Genuine ring, silenced by btn_dec.
        set_cur(5'd0, 6'd1, 6'd0);
        @(negedge clk);
        check("ring_set", 32'(bus.ringing), 1);
        bus.cur_sec = 6'd1;
        pulse(0, 0, 1);
        check("ring_cleared", 32'(bus.ringing), 0);
        check("ring_press_consumed", 32'(bus.mode), 0);
        check("run_disp_cur", 32'(bus.disp_min), 1);

        // Ring again, snooze with btn_inc, expect re-ring at 00:06 only with snooze.
        set_cur(5'd0, 6'd1, 6'd0);
        @(negedge clk);
        check("ring2_set", 32'(bus.ringing), 1);
        bus.cur_sec = 6'd1;
        pulse(0, 1, 0);
        check("snooze_cleared", 32'(bus.ringing), 0);
        check("snooze_mode", 32'(bus.mode), 0);
        set_cur(5'd0, 6'd6, 6'd0);
        @(negedge clk);
        check("snooze_rering", 32'(bus.ringing), SnzRing);
        bus.cur_sec = 6'd1;
        pulse(0, 0, 1);
        check("rering_cleared", 32'(bus.ringing), 0);

        // Wrap and priority in SET_HOUR / SET_MIN.
        set_cur(5'd23, 6'd0, 6'd5);
        pulse(1, 0, 0);
        check("wrap_enter", 32'(bus.disp_hour), 23);
        pulse(0, 1, 0);
        check("hour_wrap_up", 32'(bus.disp_hour), 0);
        pulse(0, 1, 1);
        check("hour_inc_dec_cancel", 32'(bus.disp_hour), 0);
        pulse(1, 1, 0);
        check("mode_beats_inc", 32'(bus.mode), 2);
        check("mode_beats_inc_hour", 32'(bus.disp_hour), 0);
        pulse(0, 0, 1);
        check("min_wrap_down", 32'(bus.disp_min), 59);

        // Timeout out of SET_MIN: no load, alarm untouched.
        load_base = load_cnt;
        repeat (29) @(negedge clk);
        check("tmo_min_not_yet", 32'(bus.mode), 2);
        @(negedge clk);
        check("tmo_min_run", 32'(bus.mode), 0);
        check("tmo_min_no_load", 32'(load_cnt - load_base), 0);
        check("tmo_alarm_kept", 32'(bus.alarm_min), 1);

        // Timeout out of SET_HOUR, 30 idle cycles after entry.
        set_cur(5'd12, 6'd34, 6'd5);
        load_base = load_cnt;
        pulse(1, 0, 0);
        repeat (29) @(negedge clk);
        check("tmo_hour_not_yet", 32'(bus.mode), 1);
        @(negedge clk);
        check("tmo_hour_run", 32'(bus.mode), 0);
        check("tmo_hour_no_load", 32'(load_cnt - load_base), 0);
        check("tmo_disp_hour", 32'(bus.disp_hour), 12);
        check("tmo_disp_min", 32'(bus.disp_min), 34);
        check("tmo_alarm_en_kept", 32'(bus.alarm_en), 1);

        // Mid-operation reset.
        pulse(1, 0, 0);
        check("pre_reset_mode", 32'(bus.mode), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_reset_mode", 32'(bus.mode), 0);
        check("mid_reset_alarm_en", 32'(bus.alarm_en), 0);
        check("mid_reset_alarm_min", 32'(bus.alarm_min), 0);
        check("mid_reset_load_min", 32'(bus.load_min), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
